pcie_tx_arbiter: RTL and testbench
==================================

Name: pcie_tx_arbiter

Overview:
- Shares the PCIe core's 64-bit TRN transmit interface between NUM_REQ TLP sources, e.g. completer, DMA write engine and DMA read-request engine.
- Arbitrates round-robin at packet boundaries and holds a grant for a whole TLP.
- Gates new packets on core buffer availability and link state.
- Sits between the DMA application engines and the core transmit port, all on trn_clk.

Parameters:
- NUM_REQ, 3: number of requesters, 2..4.
- MIN_BUF_AV, 2: minimum trn_tbuf_av value required to start a packet.
- PRIO0, 0: when 1, requester 0 (completions) always wins if requesting; otherwise pure round-robin.

Ports:
- trn_clk  in  1  transmit clock; all logic on this clock.
- trn_reset  in  1  asynchronous, active-high reset.
- trn_lnk_up_n  in  1  link up, active low.
- req_tsof_n  in  NUM_REQ  per-requester start of frame.
- req_teof_n  in  NUM_REQ  per-requester end of frame.
- req_td  in  64*NUM_REQ  per-requester data; requester i occupies bits [64i+63:64i].
- req_trem_n  in  NUM_REQ  per-requester remainder (1 = upper DW valid only).
- req_tsrc_rdy_n  in  NUM_REQ  per-requester valid.
- req_tdst_rdy_n  out  NUM_REQ  per-requester accept.
- trn_tsof_n  out  1  to core.
- trn_teof_n  out  1  to core.
- trn_td  out  64  to core.
- trn_trem_n  out  1  to core.
- trn_tsrc_rdy_n  out  1  to core.
- trn_tsrc_dsc_n  out  1  to core.
- trn_tdst_rdy_n  in  1  core ready.
- trn_tbuf_av  in  6  core transmit buffers available.
- grant  out  NUM_REQ  one-hot current owner, registered.
- drop_cnt  out  16  packets flushed due to link down, saturating.
- proto_err  out  1  sticky: a requester presented a non-SOF beat while idle.

Behaviour:
- Reset values, asynchronous on trn_reset:
  - state=IDLE, grant=0, rr_ptr=0, drop_cnt=0, proto_err=0.
  - trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_dsc_n all 1; trn_td=0.
  - req_tdst_rdy_n all 1.
- States: IDLE, XFER, FLUSH.
- IDLE:
  - Candidates are requesters with tsrc_rdy_n=0 and tsof_n=0.
  - A winner is picked only when trn_lnk_up_n=0 and trn_tbuf_av>=MIN_BUF_AV.
  - Winner is the first candidate at or after rr_ptr, modulo NUM_REQ; with PRIO0=1, requester 0 wins whenever it is a candidate.
  - On a pick, grant is registered and the state moves to XFER next cycle. This is a one-cycle arbitration bubble per packet.
  - No beats are accepted in IDLE: all req_tdst_rdy_n=1 and trn outputs are inactive.
- XFER: combinational pass-through of the granted requester.
  - tsof_n, teof_n, td, trem_n and tsrc_rdy_n go to trn_*.
  - trn_tdst_rdy_n goes to that requester's req_tdst_rdy_n; all others are held at 1.
  - A beat transfers when src_rdy and dst_rdy are both low.
  - Transfer with teof_n=0: next state IDLE, grant=0, rr_ptr=winner+1 mod NUM_REQ.
  - A single-beat TLP (sof and eof together) is legal.
  - trn_tbuf_av is not rechecked mid-packet.
- Link loss: trn_lnk_up_n=1 sampled in XFER.
  - Next cycle: state=FLUSH, trn_tsrc_rdy_n=1.
  - The requester is drained with req_tdst_rdy_n=0 until its EOF beat.
  - On EOF: drop_cnt += 1 (saturating at 16'hFFFF), state IDLE, rr_ptr advanced.
  - trn_tsrc_dsc_n stays 1, because the core drops the partial TLP on link down.
- proto_err is set when, in IDLE, some requester has tsrc_rdy_n=0 with tsof_n=1. The arbiter never grants on such a beat. proto_err is cleared only by reset.
- Simultaneous requests are resolved only by the pointer/priority rule; the rule is deterministic.
- rr_ptr does not change on cycles where no packet completes.
- Reset mid-packet: outputs go inactive immediately, asynchronously. The requester is responsible for restarting its TLP.

Test Plan:
- Single requester 1 sends a 4-beat TLP with tbuf_av=10 and link up → grant=3'b010 one cycle after request; 4 beats appear on trn_td in order; last beat has trn_teof_n=0; grant returns to 0.
- Requesters 0, 1 and 2 all request continuous 2-beat TLPs with PRIO0=0 → grant order 0,1,2,0,1,2. Each packet takes 3 cycles (bubble + 2 beats).
- PRIO0=1 with requesters 0 and 2 continuously requesting → requester 0 wins every arbitration; requester 2 is never granted while 0 requests.
- trn_tdst_rdy_n toggles 1,0,1,0 during a 3-beat TLP → exactly 3 transfers with no duplicated or lost beats; req_tdst_rdy_n of the granted requester mirrors trn_tdst_rdy_n.
- tbuf_av=1 with a request pending → no grant; raising tbuf_av to 2 → grant the following cycle.
- trn_lnk_up_n rises after beat 2 of a 5-beat TLP → trn_tsrc_rdy_n=1 from the next cycle; beats 3–5 are drained; drop_cnt=1; arbiter returns to IDLE. Separately, a requester with src_rdy=0 and sof=1 while IDLE → proto_err=1.

Source files
------------

// File: rtl/pcie_tx_arbiter.sv
// Shares the 64-bit TRN transmit port between NUM_REQ TLP sources, arbitrating at packet
// boundaries; a link drop mid-packet drains the owner without forwarding and counts a drop.
module pcie_tx_arbiter #(
  parameter  int unsigned NUM_REQ    = 3,
  parameter  int unsigned MIN_BUF_AV = 2,
  parameter  bit          PRIO0      = 1'b0,
  localparam int unsigned TD_W       = 64,
  localparam int unsigned BUF_W      = 6,
  localparam int unsigned CNT_W      = 16
) (
  input  logic                    trn_clk,
  input  logic                    trn_reset,
  input  logic                    trn_lnk_up_n,
  input  logic [NUM_REQ-1:0]      req_tsof_n,
  input  logic [NUM_REQ-1:0]      req_teof_n,
  input  logic [TD_W*NUM_REQ-1:0] req_td,
  input  logic [NUM_REQ-1:0]      req_trem_n,
  input  logic [NUM_REQ-1:0]      req_tsrc_rdy_n,
  output logic [NUM_REQ-1:0]      req_tdst_rdy_n,
  output logic                    trn_tsof_n,
  output logic                    trn_teof_n,
  output logic [TD_W-1:0]         trn_td,
  output logic                    trn_trem_n,
  output logic                    trn_tsrc_rdy_n,
  output logic                    trn_tsrc_dsc_n,
  input  logic                    trn_tdst_rdy_n,
  input  logic [BUF_W-1:0]        trn_tbuf_av,
  output logic [NUM_REQ-1:0]      grant,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    proto_err
);
  localparam int unsigned PTR_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_FLUSH} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]   r_drop_cnt, w_drop_cnt_nxt;
  logic               r_proto_err, w_proto_err_nxt;

  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_bad_sof;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W-1:0]   w_owner_inc;
  logic               w_found;
  logic               w_can_start;
  logic               w_own_vld;
  logic               w_own_eof;
  logic               w_done;

  assign w_cand      = ~req_tsrc_rdy_n & ~req_tsof_n;
  assign w_bad_sof   = ~req_tsrc_rdy_n & req_tsof_n;
  assign w_can_start = !trn_lnk_up_n && (trn_tbuf_av >= BUF_W'(MIN_BUF_AV));
  assign w_own_vld   = !req_tsrc_rdy_n[r_owner];
  assign w_own_eof   = !req_teof_n[r_owner];
  assign w_owner_inc = (32'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;

  // First candidate at or after the round-robin pointer; requester 0 overrides when prioritised
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = PTR_W'((32'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    if (PRIO0 && w_cand[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
  end

  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_owner_nxt     = r_owner;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_drop_cnt_nxt  = r_drop_cnt;
    w_proto_err_nxt = r_proto_err;
    w_done          = 1'b0;
    trn_tsof_n      = 1'b1;
    trn_teof_n      = 1'b1;
    trn_td          = '0;
    trn_trem_n      = 1'b1;
    trn_tsrc_rdy_n  = 1'b1;
    trn_tsrc_dsc_n  = 1'b1;
    req_tdst_rdy_n  = '1;
    case (r_state)
      S_IDLE: begin
        if (|w_bad_sof) w_proto_err_nxt = 1'b1;
        if (w_found && w_can_start) begin
          w_state_nxt = S_XFER;
          w_owner_nxt = w_win;
          w_grant_nxt = NUM_REQ'(1) << w_win;
        end
      end
      S_XFER: begin
        trn_tsof_n              = req_tsof_n[r_owner];
        trn_teof_n              = req_teof_n[r_owner];
        trn_td                  = req_td[TD_W*32'(r_owner) +: TD_W];
        trn_trem_n              = req_trem_n[r_owner];
        trn_tsrc_rdy_n          = req_tsrc_rdy_n[r_owner];
        req_tdst_rdy_n[r_owner] = trn_tdst_rdy_n;
        if (w_own_vld && !trn_tdst_rdy_n && w_own_eof) w_done = 1'b1;
        else if (trn_lnk_up_n)                         w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        // Core has already discarded the partial TLP; swallow the rest locally
        req_tdst_rdy_n[r_owner] = 1'b0;
        if (w_own_vld && w_own_eof) begin
          w_done = 1'b1;
          if (r_drop_cnt != '1) w_drop_cnt_nxt = r_drop_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_done) begin
      w_state_nxt  = S_IDLE;
      w_grant_nxt  = '0;
      w_rr_ptr_nxt = w_owner_inc;
    end
  end

  always_ff @(posedge trn_clk or posedge trn_reset) begin
    if (trn_reset) begin
      r_grant     <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_drop_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  assign grant     = r_grant;
  assign drop_cnt  = r_drop_cnt;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: a directed vector table, corner sequences and random traffic
// checked against a packet-level reference model, with PRIO0=0 and PRIO0=1 instances.
module tb_pcie_tx_arbiter;
  localparam int NR   = 3;
  localparam int MINB = 2;

  typedef struct packed {
    logic [NR-1:0] grant;
    logic          src_n;
    logic          sof_n;
    logic          eof_n;
    logic          trem_n;
    logic          dsc_n;
    logic [63:0]   td;
    logic [NR-1:0] rdst_n;
    logic [15:0]   drop;
    logic          perr;
  } obs_t;

  typedef struct {
    logic        sof;
    logic        eof;
    logic        trem;
    logic [63:0] d;
  } beat_t;

  typedef struct {
    logic          src_n, sof_n, eof_n;
    logic [63:0]   td;
    logic          dst_n;
    logic [5:0]    tbuf;
    logic [NR-1:0] e_grant;
    logic          e_src_n, e_sof_n, e_eof_n;
    logic [63:0]   e_td;
    logic [NR-1:0] e_rdst;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            lnk_up_n = 1'b0;
  logic [NR-1:0]   src_n = '1, sof_n = '1, eof_n = '1, trem_in_n = '1;
  logic [64*NR-1:0] td_in = '0;
  logic            core_dst_n = 1'b0;
  logic [5:0]      tbuf_av = 6'd10;

  logic [NR-1:0]   a_rdst, a_grant, b_rdst, b_grant;
  logic            a_sof_n, a_eof_n, a_trem_n, a_src_n, a_dsc_n;
  logic            b_sof_n, b_eof_n, b_trem_n, b_src_n, b_dsc_n;
  logic [63:0]     a_td, b_td;
  logic [15:0]     a_drop, b_drop;
  logic            a_perr, b_perr;
  obs_t            obs_a, obs_b, last_act;

  always #5 clk = ~clk;

  pcie_tx_arbiter #(.NUM_REQ(NR), .MIN_BUF_AV(MINB), .PRIO0(1'b0)) u_rr (
    .trn_clk(clk), .trn_reset(rst), .trn_lnk_up_n(lnk_up_n),
    .req_tsof_n(sof_n), .req_teof_n(eof_n), .req_td(td_in), .req_trem_n(trem_in_n),
    .req_tsrc_rdy_n(src_n), .req_tdst_rdy_n(a_rdst),
    .trn_tsof_n(a_sof_n), .trn_teof_n(a_eof_n), .trn_td(a_td), .trn_trem_n(a_trem_n),
    .trn_tsrc_rdy_n(a_src_n), .trn_tsrc_dsc_n(a_dsc_n), .trn_tdst_rdy_n(core_dst_n),
    .trn_tbuf_av(tbuf_av), .grant(a_grant), .drop_cnt(a_drop), .proto_err(a_perr)
  );

  pcie_tx_arbiter #(.NUM_REQ(NR), .MIN_BUF_AV(MINB), .PRIO0(1'b1)) u_prio (
    .trn_clk(clk), .trn_reset(rst), .trn_lnk_up_n(lnk_up_n),
    .req_tsof_n(sof_n), .req_teof_n(eof_n), .req_td(td_in), .req_trem_n(trem_in_n),
    .req_tsrc_rdy_n(src_n), .req_tdst_rdy_n(b_rdst),
    .trn_tsof_n(b_sof_n), .trn_teof_n(b_eof_n), .trn_td(b_td), .trn_trem_n(b_trem_n),
    .trn_tsrc_rdy_n(b_src_n), .trn_tsrc_dsc_n(b_dsc_n), .trn_tdst_rdy_n(core_dst_n),
    .trn_tbuf_av(tbuf_av), .grant(b_grant), .drop_cnt(b_drop), .proto_err(b_perr)
  );

  assign obs_a = {a_grant, a_src_n, a_sof_n, a_eof_n, a_trem_n, a_dsc_n, a_td, a_rdst, a_drop, a_perr};
  assign obs_b = {b_grant, b_src_n, b_sof_n, b_eof_n, b_trem_n, b_dsc_n, b_td, b_rdst, b_drop, b_perr};

  int      n_vec = 0;
  int      n_err = 0;
  bit      use_b = 1'b0;
  bit      table_mode = 1'b0;
  int      gap_pct = 0;
  int      pkt_id = 0;
  beat_t   rq[NR][$];
  int      glog[$];
  logic [NR-1:0] prev_grant = '0;

  // Reference model: who owns the port, whether it is being discarded, and packet-level counters
  int m_owner = -1;
  bit m_flush = 1'b0;
  int m_ptr   = 0;
  int m_drop  = 0;
  bit m_perr  = 1'b0;
  bit m_prio  = 1'b0;

  task automatic m_reset();
    m_owner = -1; m_flush = 1'b0; m_ptr = 0; m_drop = 0; m_perr = 1'b0;
    prev_grant = '0;
    glog.delete();
  endtask

  function automatic int pick(input logic [NR-1:0] cand);
    if (m_prio && cand[0]) return 0;
    for (int k = 0; k < NR; k++)
      if (cand[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.grant = '0; o.src_n = 1'b1; o.sof_n = 1'b1; o.eof_n = 1'b1; o.trem_n = 1'b1;
    o.dsc_n = 1'b1; o.td = '0; o.rdst_n = '1; o.drop = 16'(m_drop); o.perr = m_perr;
    if (m_owner >= 0) begin
      o.grant[m_owner] = 1'b1;
      if (m_flush) o.rdst_n[m_owner] = 1'b0;
      else begin
        o.src_n  = src_n[m_owner];
        o.sof_n  = sof_n[m_owner];
        o.eof_n  = eof_n[m_owner];
        o.trem_n = trem_in_n[m_owner];
        o.td     = td_in[64*m_owner +: 64];
        o.rdst_n[m_owner] = core_dst_n;
      end
    end
    return o;
  endfunction

  task automatic model_step();
    logic [NR-1:0] cand;
    int w;
    bit took;
    cand = ~src_n & ~sof_n;
    if (m_owner < 0) begin
      if ((~src_n & sof_n) != '0) m_perr = 1'b1;
      if (!lnk_up_n && tbuf_av >= 6'(MINB)) begin
        w = pick(cand);
        if (w >= 0) begin m_owner = w; m_flush = 1'b0; end
      end
    end else begin
      took = !src_n[m_owner] && (m_flush || !core_dst_n);
      if (took && !eof_n[m_owner]) begin
        if (m_flush && m_drop < 65535) m_drop++;
        m_ptr = (m_owner + 1) % NR;
        m_owner = -1;
        m_flush = 1'b0;
      end else if (!m_flush && lnk_up_n) m_flush = 1'b1;
    end
  endtask

  task automatic check_obs(input string nm, input obs_t act, input obs_t exp_o);
    n_vec++;
    if (act !== exp_o) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp_o);
    end
  endtask

  task automatic check_val(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp_v);
    end
  endtask

  function automatic int oh2i(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic push_pkt(input int i, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.sof  = (k == 0);
      b.eof  = (k == len - 1);
      b.trem = (k == len - 1) ? 1'($urandom_range(1)) : 1'b0;
      b.d    = {8'(i), 24'(pkt_id), 32'(k)};
      rq[i].push_back(b);
    end
    pkt_id++;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        src_n[i] = 1'b0; sof_n[i] = ~rq[i][0].sof; eof_n[i] = ~rq[i][0].eof;
        trem_in_n[i] = ~rq[i][0].trem; td_in[64*i +: 64] = rq[i][0].d;
      end else begin
        src_n[i] = 1'b1; sof_n[i] = 1'b1; eof_n[i] = 1'b1; trem_in_n[i] = 1'b1;
        td_in[64*i +: 64] = {$urandom, $urandom};
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then pop accepted beats
  task automatic tick();
    obs_t ex;
    logic [NR-1:0] rd, pop;
    @(negedge clk);
    last_act = use_b ? obs_b : obs_a;
    rd = use_b ? b_rdst : a_rdst;
    ex = model_out();
    check_obs("cycle", last_act, ex);
    if (last_act.grant != '0 && prev_grant == '0) glog.push_back(oh2i(last_act.grant));
    prev_grant = last_act.grant;
    pop = ~src_n & ~rd;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (pop[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    if (!table_mode) drive_reqs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    check_obs("reset_outputs", use_b ? obs_b : obs_a, model_out());
    for (int i = 0; i < NR; i++) rq[i].delete();
    drive_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive_reqs();
  endtask

  task automatic run_drain(input int max_cyc, output int used);
    used = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size()) > 0 && used < max_cyc) begin
      tick();
      used++;
    end
    n_vec++;
    if ((rq[0].size() + rq[1].size() + rq[2].size()) > 0) begin
      n_err++;
      $display("FAIL drain_timeout t=%0t got=%0d beats left want=0", $time,
               rq[0].size() + rq[1].size() + rq[2].size());
    end
  endtask

  function automatic vec_t mkv(input logic s, input logic so, input logic eo, input logic [63:0] d,
                               input logic dst, input logic [5:0] tb, input logic [NR-1:0] eg,
                               input logic es, input logic eso, input logic eeo,
                               input logic [63:0] ed, input logic [NR-1:0] er);
    vec_t v;
    v.src_n = s; v.sof_n = so; v.eof_n = eo; v.td = d; v.dst_n = dst; v.tbuf = tb;
    v.e_grant = eg; v.e_src_n = es; v.e_sof_n = eso; v.e_eof_n = eeo; v.e_td = ed; v.e_rdst = er;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t got=no finish want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    int   used;
    int   exp_rr[6];
    int   exp_pr[6];
    int   link_dn;
    logic [63:0] d1, d2, d3, d4;
    d1 = 64'h1111_0000_AAAA_0001; d2 = 64'h2222_0000_AAAA_0002;
    d3 = 64'h3333_0000_AAAA_0003; d4 = 64'h4444_0000_AAAA_0004;
    // Requester 1 alone: buffer gating, then a 4-beat TLP under core back-pressure
    vt[0]  = mkv(1, 1, 1, '0, 0, 10, 3'b000, 1, 1, 1, '0, 3'b111);
    vt[1]  = mkv(0, 0, 1, d1, 0, 1,  3'b000, 1, 1, 1, '0, 3'b111);
    vt[2]  = mkv(0, 0, 1, d1, 0, 1,  3'b000, 1, 1, 1, '0, 3'b111);
    vt[3]  = mkv(0, 0, 1, d1, 0, 2,  3'b000, 1, 1, 1, '0, 3'b111);
    vt[4]  = mkv(0, 0, 1, d1, 0, 2,  3'b010, 0, 0, 1, d1, 3'b101);
    vt[5]  = mkv(0, 1, 1, d2, 1, 2,  3'b010, 0, 1, 1, d2, 3'b111);
    vt[6]  = mkv(0, 1, 1, d2, 0, 2,  3'b010, 0, 1, 1, d2, 3'b101);
    vt[7]  = mkv(0, 1, 1, d3, 1, 2,  3'b010, 0, 1, 1, d3, 3'b111);
    vt[8]  = mkv(0, 1, 1, d3, 0, 2,  3'b010, 0, 1, 1, d3, 3'b101);
    vt[9]  = mkv(0, 1, 0, d4, 0, 0,  3'b010, 0, 1, 0, d4, 3'b101);
    vt[10] = mkv(1, 1, 1, '0, 0, 10, 3'b000, 1, 1, 1, '0, 3'b111);
    exp_rr = '{0, 1, 2, 0, 1, 2};
    exp_pr = '{0, 0, 0, 0, 2, 2};

    use_b = 1'b0; m_prio = 1'b0; table_mode = 1'b1;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      src_n = {1'b1, vt[k].src_n, 1'b1};
      sof_n = {1'b1, vt[k].sof_n, 1'b1};
      eof_n = {1'b1, vt[k].eof_n, 1'b1};
      trem_in_n = '1;
      td_in = {64'h0, vt[k].td, 64'h0};
      core_dst_n = vt[k].dst_n;
      tbuf_av = vt[k].tbuf;
      tick();
      check_val($sformatf("table_%0d", k),
                128'({last_act.grant, last_act.src_n, last_act.sof_n, last_act.eof_n, last_act.td, last_act.rdst_n}),
                128'({vt[k].e_grant, vt[k].e_src_n, vt[k].e_sof_n, vt[k].e_eof_n, vt[k].e_td, vt[k].e_rdst}));
    end

    // Three requesters with back-to-back 2-beat TLPs rotate 0,1,2 at 3 cycles per packet
    table_mode = 1'b0; core_dst_n = 1'b0; tbuf_av = 6'd10; lnk_up_n = 1'b0; gap_pct = 0;
    do_reset();
    for (int p = 0; p < 2; p++) for (int i = 0; i < NR; i++) push_pkt(i, 2);
    drive_reqs();
    run_drain(60, used);
    check_val("rr_cycles", 128'(used), 128'(18));
    check_val("rr_count", 128'(glog.size()), 128'(6));
    for (int k = 0; k < 6 && k < glog.size(); k++)
      check_val($sformatf("rr_order_%0d", k), 128'(glog[k]), 128'(exp_rr[k]));

    // Requester 0 prioritised: requester 2 waits until 0 has nothing left
    use_b = 1'b1; m_prio = 1'b1;
    do_reset();
    for (int p = 0; p < 4; p++) push_pkt(0, 2);
    for (int p = 0; p < 2; p++) push_pkt(2, 2);
    drive_reqs();
    run_drain(60, used);
    check_val("prio_count", 128'(glog.size()), 128'(6));
    for (int k = 0; k < 6 && k < glog.size(); k++)
      check_val($sformatf("prio_order_%0d", k), 128'(glog[k]), 128'(exp_pr[k]));

    // Link drops after beat 2 of a 5-beat TLP: the remaining 3 beats are swallowed
    use_b = 1'b0; m_prio = 1'b0;
    do_reset();
    push_pkt(1, 5);
    drive_reqs();
    repeat (3) tick();
    check_val("flush_pre_left", 128'(rq[1].size()), 128'(3));
    lnk_up_n = 1'b1; core_dst_n = 1'b1;
    tick();
    tick();
    check_val("flush_src_rdy", 128'(last_act.src_n), 128'(1));
    check_val("flush_rdst", 128'(last_act.rdst_n), 128'(3'b101));
    repeat (2) tick();
    check_val("flush_left", 128'(rq[1].size()), 128'(0));
    tick();
    check_val("flush_drop", 128'(last_act.drop), 128'(1));
    check_val("flush_grant", 128'(last_act.grant), 128'(0));
    lnk_up_n = 1'b0; core_dst_n = 1'b0;

    // Non-SOF beat offered while idle: flagged, never granted, and sticky
    table_mode = 1'b1;
    do_reset();
    src_n = 3'b011; sof_n = 3'b111; eof_n = 3'b111;
    tick();
    src_n = 3'b111;
    tick();
    check_val("perr_set", 128'(last_act.perr), 128'(1));
    check_val("perr_nogrant", 128'(last_act.grant), 128'(0));
    repeat (2) tick();
    check_val("perr_sticky", 128'(last_act.perr), 128'(1));

    // Reset in the middle of a packet drops every output at once
    table_mode = 1'b0;
    push_pkt(0, 4);
    drive_reqs();
    repeat (2) tick();
    check_val("midpkt_granted", 128'(last_act.grant), 128'(3'b001));
    do_reset();

    // Random traffic, gaps, back-pressure, buffer starvation and link drops
    for (int pass = 0; pass < 2; pass++) begin
      use_b = (pass == 1); m_prio = (pass == 1); gap_pct = 20; link_dn = 0;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < NR; i++)
          if (rq[i].size() == 0 && $urandom_range(3) == 0) push_pkt(i, int'($urandom_range(1, 5)));
        core_dst_n = ($urandom_range(9) < 3);
        tbuf_av = 6'($urandom_range(0, 8));
        if (link_dn > 0) link_dn--;
        else if ($urandom_range(99) < 2) link_dn = int'($urandom_range(1, 6));
        lnk_up_n = (link_dn > 0);
        tick();
      end
      lnk_up_n = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
